multi_pad_reader: RTL and testbench

MULTI_PAD_READER -- requirements
Module: multi_pad_reader

---
 rtl/multi_pad_pkg.sv | 26 ++
 rtl/pad_shift_chan.sv | 53 +++++
 rtl/multi_pad_reader.sv | 170 +++++++++++++++++
 tb/tb_multi_pad_reader.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/multi_pad_pkg.sv
// rtl/multi_pad_pkg.sv - shared state type and parameter limits for the pad reader
package multi_pad_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LATCH,
    ST_SHIFT_HI,
    ST_SHIFT_LO,
    ST_DONE
  } pad_state_t;

  localparam int DEF_CHANNELS      = 2;
  localparam int MIN_CHANNELS      = 1;
  localparam int MAX_CHANNELS      = 8;

  localparam int DEF_BITS          = 8;
  localparam int MIN_BITS          = 1;
  localparam int MAX_BITS          = 32;

  localparam int DEF_HALF_PERIOD   = 30;
  localparam int MIN_HALF_PERIOD   = 4;

  localparam int DEF_POLL_INTERVAL = 16000;
  localparam int MIN_POLL_INTERVAL = 1;

endpackage

// File: rtl/pad_shift_chan.sv
// rtl/pad_shift_chan.sv - per-pad data synchroniser and shadow shift register
module pad_shift_chan
  import multi_pad_pkg::*;
#(
  parameter int BITS = DEF_BITS
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            din,
  input  logic            clear,
  input  logic            sample,
  output logic [BITS-1:0] shadow
);

  logic sync1;
  logic sync2;

  if (BITS < MIN_BITS || BITS > MAX_BITS) begin : g_bad_bits
    $error("pad_shift_chan: BITS out of range");
  end

  // Two-flop synchroniser: pad data is asynchronous to SYSCLK
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
    end
  end

  if (BITS == 1) begin : g_single
    // Single-button pad: the one sample is the whole frame (stored inverted, 1 = pressed)
    always_ff @(posedge clk) begin
      if (rst || clear) begin
        shadow <= '0;
      end else if (sample) begin
        shadow <= ~sync2;
      end
    end
  end else begin : g_multi
    // Shift in from the top so that the first sampled bit ends up at index 0
    always_ff @(posedge clk) begin
      if (rst || clear) begin
        shadow <= '0;
      end else if (sample) begin
        shadow <= {~sync2, shadow[BITS-1:1]};
      end
    end
  end

endmodule

// File: rtl/multi_pad_reader.sv
// rtl/multi_pad_reader.sv - latches and shifts several serial pads in parallel
module multi_pad_reader
  import multi_pad_pkg::*;
#(
  parameter int CHANNELS      = DEF_CHANNELS,
  parameter int BITS          = DEF_BITS,
  parameter int HALF_PERIOD   = DEF_HALF_PERIOD,
  parameter int POLL_INTERVAL = DEF_POLL_INTERVAL
) (
  input  logic                     SYSCLK,
  input  logic                     SYSRESET,
  input  logic                     start,
  input  logic                     auto_en,
  input  logic [CHANNELS-1:0]      data,
  output logic                     poll,
  output logic                     pad_clk,
  output logic [CHANNELS*BITS-1:0] buttonData,
  output logic                     ready,
  output logic [CHANNELS-1:0]      changed,
  output logic                     busy
);

  localparam int TW = $clog2(HALF_PERIOD);
  localparam int BW = $clog2(BITS + 1);
  localparam int AW = $clog2(POLL_INTERVAL + 1);

  if (CHANNELS < MIN_CHANNELS || CHANNELS > MAX_CHANNELS) begin : g_bad_channels
    $error("multi_pad_reader: CHANNELS out of range");
  end
  if (BITS < MIN_BITS || BITS > MAX_BITS) begin : g_bad_bits
    $error("multi_pad_reader: BITS out of range");
  end
  if (HALF_PERIOD < MIN_HALF_PERIOD) begin : g_bad_half_period
    $error("multi_pad_reader: HALF_PERIOD too small");
  end
  if (POLL_INTERVAL < MIN_POLL_INTERVAL) begin : g_bad_poll_interval
    $error("multi_pad_reader: POLL_INTERVAL too small");
  end

  pad_state_t               state;
  pad_state_t               state_nx;
  logic [TW-1:0]            div_cnt;
  logic                     tick;
  logic                     tick_idx;
  logic [BW-1:0]            bit_cnt;
  logic [AW-1:0]            auto_cnt;
  logic                     auto_req;
  logic                     sample_en;
  logic                     clear_en;
  logic [CHANNELS*BITS-1:0] shadow;

  assign tick     = (div_cnt == TW'(HALF_PERIOD - 1));
  assign auto_req = auto_en && (state == ST_IDLE) && (auto_cnt == AW'(POLL_INTERVAL - 1));

  // State register
  always_ff @(posedge SYSCLK) begin
    if (SYSRESET) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Half-period divider; restarts on every state change so each state lasts whole ticks
  always_ff @(posedge SYSCLK) begin
    if (SYSRESET || (state_nx != state)) begin
      div_cnt  <= '0;
      tick_idx <= 1'b0;
    end else if (tick) begin
      div_cnt  <= '0;
      tick_idx <= ~tick_idx;
    end else begin
      div_cnt  <= div_cnt + 1'b1;
    end
  end

  // Number of bits already captured in the current frame
  always_ff @(posedge SYSCLK) begin
    if (SYSRESET || clear_en) begin
      bit_cnt <= '0;
    end else if (sample_en) begin
      bit_cnt <= bit_cnt + 1'b1;
    end
  end

  // Auto-poll timer: counts idle cycles, restarts after each frame and when it fires
  always_ff @(posedge SYSCLK) begin
    if (SYSRESET || !auto_en || (state == ST_DONE) || auto_req) begin
      auto_cnt <= '0;
    end else if (state == ST_IDLE) begin
      auto_cnt <= auto_cnt + 1'b1;
    end
  end

  // Next-state, pad strobes and shift-register enables
  always_comb begin
    state_nx  = state;
    sample_en = 1'b0;
    clear_en  = 1'b0;
    poll      = 1'b0;
    pad_clk   = 1'b0;
    busy      = 1'b1;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start || auto_req) begin
          state_nx = ST_LATCH;
          clear_en = 1'b1;
        end
      end
      ST_LATCH: begin
        poll = 1'b1;
        if (tick && tick_idx) begin
          sample_en = 1'b1;
          state_nx  = (BITS == 1) ? ST_DONE : ST_SHIFT_HI;
        end
      end
      ST_SHIFT_HI: begin
        pad_clk = 1'b1;
        if (tick) begin
          state_nx = ST_SHIFT_LO;
        end
      end
      ST_SHIFT_LO: begin
        if (tick) begin
          sample_en = 1'b1;
          state_nx  = (bit_cnt == BW'(BITS - 1)) ? ST_DONE : ST_SHIFT_HI;
        end
      end
      ST_DONE: begin
        state_nx = ST_IDLE;
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  // Publish a complete frame atomically, with per-channel change flags
  always_ff @(posedge SYSCLK) begin
    if (SYSRESET) begin
      buttonData <= '0;
      changed    <= '0;
      ready      <= 1'b0;
    end else begin
      ready <= 1'b0;
      if (state == ST_DONE) begin
        buttonData <= shadow;
        ready      <= 1'b1;
        for (int c = 0; c < CHANNELS; c++) begin
          changed[c] <= |(shadow[c*BITS +: BITS] ^ buttonData[c*BITS +: BITS]);
        end
      end
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    pad_shift_chan #(
      .BITS(BITS)
    ) u_chan (
      .clk   (SYSCLK),
      .rst   (SYSRESET),
      .din   (data[c]),
      .clear (clear_en),
      .sample(sample_en),
      .shadow(shadow[c*BITS +: BITS])
    );
  end

endmodule

// File: tb/tb_multi_pad_reader.sv
// tb/tb_multi_pad_reader.sv - directed scoreboard bench for multi_pad_reader
module tb_multi_pad_reader;

  localparam int CH = 2;
  localparam int NB = 8;
  localparam int HP = 4;
  localparam int PI = 20;

  logic             SYSCLK = 1'b0;
  logic             SYSRESET;
  logic             start;
  logic             auto_en;
  logic [CH-1:0]    data;
  logic             poll;
  logic             pad_clk;
  logic [CH*NB-1:0] buttonData;
  logic             ready;
  logic [CH-1:0]    changed;
  logic             busy;

  typedef struct {
    logic [CH*NB-1:0] bd;
    logic [CH-1:0]    chg;
  } exp_t;

  exp_t                   sb[$];
  logic [CH-1:0][NB-1:0]  press = '0;
  logic [CH*NB-1:0]       prev_exp = '0;
  int                     errors = 0;
  int                     checks = 0;

  int   n, lat, rc, ready_at;
  int   p_err, k_err, b_err, r_err;
  logic exp_poll, exp_clk, exp_busy, exp_rdy;

  always #5 SYSCLK = ~SYSCLK;

  multi_pad_reader #(
    .CHANNELS     (CH),
    .BITS         (NB),
    .HALF_PERIOD  (HP),
    .POLL_INTERVAL(PI)
  ) dut (
    .SYSCLK    (SYSCLK),
    .SYSRESET  (SYSRESET),
    .start     (start),
    .auto_en   (auto_en),
    .data      (data),
    .poll      (poll),
    .pad_clk   (pad_clk),
    .buttonData(buttonData),
    .ready     (ready),
    .changed   (changed),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp();
    exp_t e;
    e.bd = press;
    for (int c = 0; c < CH; c++) begin
      e.chg[c] = |(press[c] ^ prev_exp[c*NB +: NB]);
    end
    sb.push_back(e);
    prev_exp = press;
  endtask

  task automatic start_timed(output int latency);
    int cnt;
    start = 1'b1;
    @(negedge SYSCLK);
    start = 1'b0;
    cnt = 1;
    while (ready !== 1'b1 && cnt < 200) begin
      @(negedge SYSCLK);
      cnt++;
    end
    latency = cnt - 1;
  endtask

  // Pad model: latch resets to bit 0, each pad_clk rise advances; active-low output
  initial begin
    int   idx;
    logic pclk_q;
    idx    = NB;
    pclk_q = 1'b0;
    data   = '1;
    forever begin
      @(negedge SYSCLK);
      if (poll === 1'b1) idx = 0;
      else if (pad_clk === 1'b1 && !pclk_q) idx++;
      pclk_q = (pad_clk === 1'b1);
      for (int c = 0; c < CH; c++) begin
        data[c] = (idx < NB) ? ~press[c][idx] : 1'b1;
      end
    end
  end

  // Scoreboard: every ready pulse pops one expected frame
  initial begin
    exp_t e;
    forever begin
      @(negedge SYSCLK);
      if (ready === 1'b1) begin
        if (sb.size() == 0) begin
          check("unexpected_ready", 1, 0);
        end else begin
          e = sb.pop_front();
          check("buttonData", buttonData, e.bd);
          check("changed", changed, e.chg);
        end
      end
    end
  end

  initial begin
    SYSRESET = 1'b1;
    start    = 1'b0;
    auto_en  = 1'b0;
    repeat (3) @(posedge SYSCLK);
    @(negedge SYSCLK);
    check("rst_poll", poll, 0);
    check("rst_pad_clk", pad_clk, 0);
    check("rst_ready", ready, 0);
    check("rst_busy", busy, 0);
    check("rst_buttonData", buttonData, 0);
    check("rst_changed", changed, 0);
    SYSRESET = 1'b0;
    repeat (3) @(negedge SYSCLK);

    // Single poll with full waveform check
    press[0] = 8'h81;
    press[1] = 8'h00;
    push_exp();
    start = 1'b1;
    p_err = 0; k_err = 0; b_err = 0; r_err = 0;
    for (int i = 1; i <= 70; i++) begin
      @(negedge SYSCLK);
      start    = 1'b0;
      exp_poll = (i <= 8);
      exp_clk  = (i >= 9) && (i <= 64) && (((i - 9) / 4) % 2 == 0);
      exp_busy = (i <= 65);
      exp_rdy  = (i == 66);
      if (poll !== exp_poll) p_err++;
      if (pad_clk !== exp_clk) k_err++;
      if (busy !== exp_busy) b_err++;
      if (ready !== exp_rdy) r_err++;
    end
    check("poll_shape", p_err, 0);
    check("pad_clk_shape", k_err, 0);
    check("busy_shape", b_err, 0);
    check("ready_timing", r_err, 0);

    // Identical repeat poll
    repeat (5) @(negedge SYSCLK);
    push_exp();
    start_timed(lat);
    check("repeat_latency", lat, 65);

    // Start pulses while busy are dropped
    repeat (5) @(negedge SYSCLK);
    press[1] = 8'h3C;
    push_exp();
    start = 1'b1;
    rc = 0;
    ready_at = 0;
    for (int i = 1; i <= 120; i++) begin
      @(negedge SYSCLK);
      start = (i == 10 || i == 40);
      if (ready === 1'b1) begin
        rc++;
        if (ready_at == 0) ready_at = i;
      end
    end
    start = 1'b0;
    check("collision_ready_count", rc, 1);
    check("collision_ready_time", ready_at, 66);
    check("collision_idle", busy, 0);

    // Auto polling
    press[0] = 8'h00;
    press[1] = 8'hFF;
    push_exp();
    push_exp();
    push_exp();
    auto_en = 1'b1;
    n = 0;
    while (ready !== 1'b1 && n < 300) begin
      @(negedge SYSCLK);
      n++;
    end
    check("auto_first_latency", n, PI + 65);
    n = 0;
    do begin
      @(negedge SYSCLK);
      n++;
    end while (ready !== 1'b1 && n < 300);
    check("auto_spacing", n, PI + 65);
    n = 0;
    do begin
      @(negedge SYSCLK);
      n++;
      if (n == 40) auto_en = 1'b0;
    end while (ready !== 1'b1 && n < 300);
    check("auto_last_spacing", n, PI + 65);
    rc = 0;
    repeat (200) begin
      @(negedge SYSCLK);
      if (ready === 1'b1) rc++;
    end
    check("auto_stopped", rc, 0);
    check("auto_idle_busy", busy, 0);
    check("auto_sb_empty", sb.size(), 0);

    // Reset during SHIFT_LO of bit 3
    press[0] = 8'h5A;
    press[1] = 8'hA5;
    start = 1'b1;
    rc = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge SYSCLK);
      start = 1'b0;
      if (i == 30) SYSRESET = 1'b1;
      if (i == 32) SYSRESET = 1'b0;
      if (ready === 1'b1) rc++;
    end
    check("abort_no_ready", rc, 0);
    check("abort_buttonData", buttonData, 0);
    check("abort_changed", changed, 0);
    check("abort_busy", busy, 0);
    prev_exp = '0;
    push_exp();
    start_timed(lat);
    check("post_reset_latency", lat, 65);

    repeat (10) @(negedge SYSCLK);
    check("final_sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
